adder4_selfcheck: RTL and testbench

Synthesizable built-in self-test engine for a 4-bit ripple adder with carry-in/carry-out. It sits on the opposite side of the adder's port list: it drives `ina`/`inb`/`cin` into the adder and reads `sum`/`cout` back. It sweeps all 512 input combinations, compares each result against an internal 5-bit golden sum, counts mismatches and captures the first failing vector. It replaces the hand-written stimulus list with an exhaustive on-chip check usable both in simulation and on FPGA.

---
 rtl/adder4_selfcheck.sv | 151 +++++++++++++++
 tb/tb_adder4_selfcheck.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adder4_selfcheck.sv
// Built-in self-test engine for a 4-bit ripple adder: sweeps all 512
// {cin,inb,ina} combinations, counts mismatches and captures the first failure.
module adder4_selfcheck #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_ina,
    output logic [3:0] dut_inb,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic       first_err_valid,
    output logic [8:0] first_err_vec,
    output logic [4:0] first_err_got
);

    localparam int unsigned VEC_W = 9;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned RES_W = 5;
    localparam int unsigned SET_W = 4;

    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(511);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               first_err_valid_q, first_err_valid_d;
    logic [VEC_W-1:0]   first_err_vec_q, first_err_vec_d;
    logic [RES_W-1:0]   first_err_got_q, first_err_got_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [RES_W-1:0]   exp_c;
    logic [RES_W-1:0]   got_c;
    logic               mismatch_c;

    // Golden sum at full 5-bit width, compared against the adder's {cout,sum}
    always_comb begin
        exp_c      = RES_W'(vec_q[3:0]) + RES_W'(vec_q[7:4]) + RES_W'(vec_q[8]);
        got_c      = {dut_cout, dut_sum};
        mismatch_c = (got_c != exp_c);
    end

    always_comb begin
        state_d           = state_q;
        vec_d             = vec_q;
        settle_cnt_d      = settle_cnt_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_got_d   = first_err_got_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d           = SETTLE;
                    vec_d             = '0;
                    settle_cnt_d      = SETTLE_LOAD;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    first_err_vec_d   = '0;
                    first_err_got_d   = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_count_d = err_count_q + CNT_W'(1);
                    if (!first_err_valid_q) begin
                        first_err_valid_d = 1'b1;
                        first_err_vec_d   = vec_q;
                        first_err_got_d   = got_c;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d        = vec_q + VEC_W'(1);
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags registered from the next state so they align with it
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            vec_q             <= '0;
            settle_cnt_q      <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= '0;
            first_err_got_q   <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            settle_cnt_q      <= settle_cnt_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_got_q   <= first_err_got_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
        end
    end

    assign dut_ina         = vec_q[3:0];
    assign dut_inb         = vec_q[7:4];
    assign dut_cin         = vec_q[8];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_got   = first_err_got_q;

endmodule

// File: tb/tb_adder4_selfcheck.sv
// Bench for adder4_selfcheck: a behavioural adder with injectable faults feeds
// two engines (default settle and settle=3); results checked against constants.
module tb_adder4_selfcheck;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    int   mode_a, mode_b;

    logic [3:0] ina_a, inb_a, sum_a, ina_b, inb_b, sum_b;
    logic       cin_a, cout_a, cin_b, cout_b;
    logic       busy_a, done_a, pass_a, fv_a, busy_b, done_b, pass_b, fv_b;
    logic [9:0] err_a, err_b;
    logic [8:0] fvec_a, fvec_b;
    logic [4:0] fgot_a, fgot_b;

    int n_vec = 0;
    int n_err = 0;

    // mode 0: good, 1: cout stuck 0, 2: sum[0] stuck 0, 3: cout stuck 1
    function automatic logic [4:0] adder_model(input int m, input logic [3:0] a,
                                               input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(c);
        case (m)
            1: r[4] = 1'b0;
            2: r[0] = 1'b0;
            3: r[4] = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout_a, sum_a} = adder_model(mode_a, ina_a, inb_a, cin_a);
    always_comb {cout_b, sum_b} = adder_model(mode_b, ina_b, inb_b, cin_b);

    adder4_selfcheck u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .dut_ina(ina_a), .dut_inb(inb_a), .dut_cin(cin_a),
        .dut_sum(sum_a), .dut_cout(cout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_valid(fv_a), .first_err_vec(fvec_a), .first_err_got(fgot_a)
    );

    adder4_selfcheck #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .dut_ina(ina_b), .dut_inb(inb_b), .dut_cin(cin_b),
        .dut_sum(sum_b), .dut_cout(cout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_valid(fv_b), .first_err_vec(fvec_b), .first_err_got(fgot_b)
    );

    typedef struct {
        string      name;
        int         mode;
        logic [9:0] exp_err;
        logic       exp_fv;
        logic [8:0] exp_vec;
        logic [4:0] exp_got;
        logic       exp_pass;
    } sweep_t;

    sweep_t tbl[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on engine A, then wait for done; optional stray starts at p1/p2
    task automatic run_a(input int p1, input int p2, output int n, output int bc);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n  = 0;
        bc = 0;
        while (!done_a && n < 5000) begin
            if (busy_a) bc++;
            start_a = (n == p1 || n == p2);
            tick();
            n++;
        end
        start_a = 1'b0;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_pass"}, 32'(pass_a), 0);
        check({tag, "_err"},  32'(err_a), 0);
        check({tag, "_fv"},   32'(fv_a), 0);
        check({tag, "_fvec"}, 32'(fvec_a), 0);
        check({tag, "_fgot"}, 32'(fgot_a), 0);
        check({tag, "_dut"},  32'({cin_a, inb_a, ina_a}), 0);
    endtask

    initial begin
        int n, bc;
        tbl[0] = '{"good",       0, 10'd0,   1'b0, 9'h000, 5'h00, 1'b1};
        tbl[1] = '{"cout_sa0",   1, 10'd256, 1'b1, 9'h01F, 5'h00, 1'b0};
        tbl[2] = '{"sum0_sa0",   2, 10'd256, 1'b1, 9'h001, 5'h00, 1'b0};
        tbl[3] = '{"cout_sa1",   3, 10'd256, 1'b1, 9'h000, 5'h10, 1'b0};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0; mode_b = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_a_reset("rst");

        for (int i = 0; i < 4; i++) begin
            mode_a = tbl[i].mode;
            run_a(-1, -1, n, bc);
            check({tbl[i].name, "_cycles"}, 32'(n), 1024);
            check({tbl[i].name, "_busy_cyc"}, 32'(bc), 1024);
            check({tbl[i].name, "_done"}, 32'(done_a), 1);
            check({tbl[i].name, "_busy"}, 32'(busy_a), 0);
            check({tbl[i].name, "_pass"}, 32'(pass_a), 32'(tbl[i].exp_pass));
            check({tbl[i].name, "_err"},  32'(err_a), 32'(tbl[i].exp_err));
            check({tbl[i].name, "_fv"},   32'(fv_a), 32'(tbl[i].exp_fv));
            check({tbl[i].name, "_fvec"}, 32'(fvec_a), 32'(tbl[i].exp_vec));
            check({tbl[i].name, "_fgot"}, 32'(fgot_a), 32'(tbl[i].exp_got));
        end

        // SETTLE_CYCLES=3: done exactly 2048 cycles after the start edge
        mode_b  = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 5000) begin
            tick();
            n++;
        end
        check("s3_cycles", 32'(n), 2048);
        check("s3_pass", 32'(pass_b), 1);
        check("s3_err", 32'(err_b), 0);

        // Reset at cycle 100 of a faulty sweep discards partial results
        mode_a  = 2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        check("mid_err", 32'(err_a), 25);
        check("mid_busy", 32'(busy_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_a_reset("midrst");
        tick();
        check("idle_hold_busy", 32'(busy_a), 0);
        mode_a = 0;
        run_a(-1, -1, n, bc);
        check("after_rst_cycles", 32'(n), 1024);
        check("after_rst_pass", 32'(pass_a), 1);

        // Stray starts at cycles 10 and 500 must not restart the sweep
        mode_a = 1;
        run_a(10, 500, n, bc);
        check("stray_cycles", 32'(n), 1024);
        check("stray_err", 32'(err_a), 256);
        check("stray_pass", 32'(pass_a), 0);

        // Start from DONE clears results and re-runs
        mode_a  = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart_done", 32'(done_a), 0);
        check("restart_pass", 32'(pass_a), 0);
        check("restart_err", 32'(err_a), 0);
        check("restart_fv", 32'(fv_a), 0);
        check("restart_busy", 32'(busy_a), 1);
        n = 0;
        while (!done_a && n < 5000) begin
            tick();
            n++;
        end
        check("restart_cycles", 32'(n), 1024);
        check("restart_final_pass", 32'(pass_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
